bram_das_beamformer: RTL and testbench
======================================

Name: bram_das_beamformer

Overview:
- Multi-channel delay-and-sum beamformer with on-chip sample buffers. Successor to the single-channel BRAM beamformer wrapper.
- Holds NUM_CH input sample buffers, a programmable integer delay per channel, and an output buffer.
- On start, a sequencer forms out[n] = average over channels c of in_c[n - delay_c], for n = 0..num_samples-1, then pulses done.
- Sits between the ADC capture logic, which fills the buffers, and the readout/UART logic, which reads the output buffer.

Parameters:
- NUM_CH, 4, channel count; must be a power of two and at least 2.
- SAMPLE_W, 12, unsigned sample width.
- ADDR_W, 11, buffer address width; depth is 2**ADDR_W.
- DELAY_W, 8, width of the per-channel delay in samples.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one sample into an input buffer.
- wr_ch  in  clog2(NUM_CH)  input buffer (channel) select.
- wr_addr  in  ADDR_W  input buffer address.
- wr_data  in  SAMPLE_W  input sample.
- delay_we  in  1  write one channel's delay.
- delay_ch  in  clog2(NUM_CH)  delay register select.
- delay_val  in  DELAY_W  delay value, in samples.
- num_samples  in  ADDR_W+1  number of output samples; legal range 0..2**ADDR_W; sampled at start.
- start  in  1  begin a run; level, sampled only in IDLE.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- rd_addr  in  ADDR_W  output buffer read address.
- rd_data  out  SAMPLE_W  output buffer data, valid 1 cycle after rd_addr.

Behaviour:
- Reset:
  - busy=0, done=0, rd_data=0; FSM goes to IDLE.
  - All delay registers are cleared to 0; index counters are cleared.
  - Buffer RAM contents are NOT cleared.
- Reset mid-run: the run aborts on the next edge with no further output writes. Output-buffer entries already written are retained.
- RAMs:
  - Synchronous read, 1-cycle latency.
  - Input buffers are single port: capture writes when IDLE, sequencer reads when busy.
  - Output buffer is dual port: sequencer writes, rd_addr reads at any time. A read of the address being written in the same cycle returns old data.
- Writes while busy: wr_en and delay_we are ignored.
- FSM:
  - IDLE: start=1 latches num_samples. If num_samples=0, go to DONE; otherwise go to RUN with n=0, c=0.
  - RUN: one channel read per cycle, ordered c=0..NUM_CH-1 for each n.
    - Address issued is n - delay_c.
    - If n < delay_c, the sample is forced to 0 and the RAM value is ignored.
    - After the last (n, c), go to FLUSH.
  - FLUSH: 2 cycles, which drain the read and accumulate pipeline.
  - DONE: done=1 for exactly 1 cycle, then IDLE.
- busy is 1 in RUN and FLUSH, and 0 in IDLE and DONE.
- start is ignored outside IDLE.
- Timing: start sampled at edge t gives a done pulse in cycle t + N*NUM_CH + 3, where N = num_samples. For N=0, done is in cycle t+1.
- Arithmetic:
  - Accumulator width is SAMPLE_W + log2(NUM_CH); it cannot overflow.
  - out[n] = acc >> log2(NUM_CH), truncating (floor).
  - out[n] is written to output address n 2 cycles after channel NUM_CH-1's read address for that n.
  - The accumulator clears at each new n.
- Wrap: n stops at N-1 and never wraps. Input addresses never go negative because of the n < delay zero-forcing.

Optional Feature:
- Macro: BF_FULL_SUM_EN.
- Defined:
  - No averaging shift; out[n] is the full channel sum.
  - Output buffer width and rd_data width become SAMPLE_W + log2(NUM_CH).
- Undefined: averaged output, SAMPLE_W wide, as described above.
- Timing and FSM are identical in both builds.

Test Plan:
- Ramp, zero delay: NUM_CH=4, all delays 0, every channel holds in[a]=a, N=8 -> out[n]=n for n=0..7.
- Delay ramp: delays {0,1,2,3}, all channels constant 400, N=6 -> out = {100, 200, 300, 400, 400, 400}. With BF_FULL_SUM_EN -> {400, 800, 1200, 1600, 1600, 1600}.
- Impulse: delays {0,1,2,3}, channel c holds 4000 at address 10-c and 0 elsewhere, N=16 -> out[10]=4000, every other out[n]=0.
- Handshake timing: N=5 -> busy rises at t+1, done pulse is exactly 1 cycle at t+23. A second start at t+5 is ignored, so only one done pulse occurs. delay_we during busy leaves the delays unchanged.
- Zero length: output address 0 preloaded with 0xABC, N=0 -> done at t+1, busy never asserts, rd_addr=0 still returns 0xABC.
- Reset mid-run: rst at t+7 -> busy=0 and done=0 after the edge, with no done pulse. A rerun with constant-400 data and no delay writes gives out[0]=400, confirming the delays were cleared.

Source files
------------

// File: rtl/bram_das_beamformer_if.sv
// Capture, delay, control and readout signals of the delay-and-sum beamformer.
// BF_FULL_SUM_EN widens rd_data to carry the unscaled channel sum.
interface bram_das_beamformer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 11,
  parameter int DELAY_W  = 8
);
  localparam int CH_W = $clog2(NUM_CH);
`ifdef BF_FULL_SUM_EN
  localparam int OUT_W = SAMPLE_W + $clog2(NUM_CH);
`else
  localparam int OUT_W = SAMPLE_W;
`endif

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                delay_we;
  logic [CH_W-1:0]     delay_ch;
  logic [DELAY_W-1:0]  delay_val;
  logic [ADDR_W:0]     num_samples;
  logic                start;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   rd_addr;
  logic [OUT_W-1:0]    rd_data;

  modport master (
    output wr_en, wr_ch, wr_addr, wr_data, delay_we, delay_ch, delay_val,
    output num_samples, start, rd_addr,
    input  busy, done, rd_data
  );

  modport slave (
    input  wr_en, wr_ch, wr_addr, wr_data, delay_we, delay_ch, delay_val,
    input  num_samples, start, rd_addr,
    output busy, done, rd_data
  );
endinterface

// File: rtl/bram_das_beamformer.sv
// Multi-channel delay-and-sum beamformer: out[n] = mean_c in_c[n - delay_c].
// Optional BF_FULL_SUM_EN stores the full channel sum instead of the mean.
module bram_das_beamformer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 11,
  parameter int DELAY_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  bram_das_beamformer_if.slave   bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SHIFT = $clog2(NUM_CH);
  localparam int ACC_W = SAMPLE_W + SHIFT;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CMP_W = (ADDR_W > DELAY_W) ? ADDR_W : DELAY_W;
`ifdef BF_FULL_SUM_EN
  localparam int OUT_W = ACC_W;
`else
  localparam int OUT_W = SAMPLE_W;
`endif

  function automatic logic [OUT_W-1:0] scale_out(input logic [ACC_W-1:0] acc);
`ifdef BF_FULL_SUM_EN
    return acc;
`else
    return OUT_W'(acc >> SHIFT);
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     num_lat;
  logic [ADDR_W-1:0]   n_idx;
  logic [CH_W-1:0]     c_idx;
  logic                flush_cnt;
  logic                last_rd;
  logic                busy;
  logic [DELAY_W-1:0]  delay_q [NUM_CH];

  assign busy     = (state == RUN) || (state == FLUSH);
  assign bus.busy = busy;
  assign bus.done = (state == DONE);
  assign last_rd  = (c_idx == CH_W'(NUM_CH - 1)) && ({1'b0, n_idx} == num_lat - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.num_samples == '0) ? DONE : RUN;
      RUN:     if (last_rd) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer counters: c is innermost, n holds at its last value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat   <= '0;
      n_idx     <= '0;
      c_idx     <= '0;
      flush_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          num_lat <= bus.num_samples;
          n_idx   <= '0;
          c_idx   <= '0;
        end
        RUN: begin
          c_idx <= c_idx + 1'b1;
          if (c_idx == CH_W'(NUM_CH - 1) && !last_rd) n_idx <= n_idx + 1'b1;
        end
        FLUSH:   flush_cnt <= ~flush_cnt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) delay_q[i] <= '0;
    end else if (bus.delay_we && !busy) begin
      delay_q[bus.delay_ch] <= bus.delay_val;
    end
  end

  // Stage p0: form the delayed read address; early samples are zero-forced
  logic [DELAY_W-1:0]         cur_dly;
  logic [ADDR_W-1:0]          rd_addr_p0;
  logic                       zero_p0;
  logic [CH_W+ADDR_W-1:0]     in_addr;
  logic [SAMPLE_W-1:0]        in_mem [0:NUM_CH*DEPTH-1];

  assign cur_dly    = delay_q[c_idx];
  assign rd_addr_p0 = n_idx - ADDR_W'(cur_dly);
  assign zero_p0    = CMP_W'(n_idx) < CMP_W'(cur_dly);
  assign in_addr    = busy ? {c_idx, rd_addr_p0} : {bus.wr_ch, bus.wr_addr};

  // Stage p1: input RAM data arrives alongside the registered sequencer tags
  logic [SAMPLE_W-1:0] ram_q_p1;
  logic                vld_p1, zero_p1, first_p1, last_p1;
  logic [ADDR_W-1:0]   n_p1;

  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy) in_mem[in_addr] <= bus.wr_data;
    ram_q_p1 <= in_mem[in_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= (state == RUN);
  end

  always_ff @(posedge clk) begin
    zero_p1  <= zero_p0;
    first_p1 <= (c_idx == '0);
    last_p1  <= (c_idx == CH_W'(NUM_CH - 1));
    n_p1     <= n_idx;
  end

  // Stage p2: accumulate; the sum for n is complete once its last channel lands
  logic [SAMPLE_W-1:0] sample_p1;
  logic [ACC_W-1:0]    acc_p2;
  logic                wr_p2;
  logic [ADDR_W-1:0]   n_p2;

  assign sample_p1 = zero_p1 ? '0 : ram_q_p1;

  always_ff @(posedge clk) begin
    if (rst) wr_p2 <= 1'b0;
    else     wr_p2 <= vld_p1 && last_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) acc_p2 <= (first_p1 ? '0 : acc_p2) + ACC_W'(sample_p1);
    n_p2 <= n_p1;
  end

  // Output buffer: sequencer write port, independent read port returning old data on collision
  logic [OUT_W-1:0] out_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_p2 && !rst) out_mem[n_p2] <= scale_out(acc_p2);
  end

  always_ff @(posedge clk) begin
    if (rst) bus.rd_data <= '0;
    else     bus.rd_data <= out_mem[bus.rd_addr];
  end
endmodule

// File: tb/tb_bram_das_beamformer.sv
// Randomised and directed bench for bram_das_beamformer against an array-based reference.
module tb_bram_das_beamformer;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int ADDR_W   = 11;
  localparam int DELAY_W  = 8;
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int NS_W     = ADDR_W + 1;
  localparam int DEPTH    = 1 << ADDR_W;
`ifdef BF_FULL_SUM_EN
  localparam longint OUT_MUL = NUM_CH;
`else
  localparam longint OUT_MUL = 1;
`endif

  logic clk, rst;
  int   n_chk, n_err;
  int   in_m  [NUM_CH][DEPTH];
  int   dly_m [NUM_CH];

  bram_das_beamformer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) bus ();

  bram_das_beamformer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mean (or sum) over channels of delayed samples, zero before the delay
  function automatic longint exp_out(input int n);
    longint sum = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (n >= dly_m[c]) sum += in_m[c][n - dly_m[c]];
`ifdef BF_FULL_SUM_EN
    return sum;
`else
    return sum / NUM_CH;
`endif
  endfunction

  task automatic wr_sample(input int ch, input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_ch = CH_W'(ch); bus.wr_addr = ADDR_W'(a); bus.wr_data = SAMPLE_W'(d);
    tick();
    bus.wr_en = 1'b0;
    in_m[ch][a] = d;
  endtask

  task automatic set_delay(input int ch, input int d);
    bus.delay_we = 1'b1; bus.delay_ch = CH_W'(ch); bus.delay_val = DELAY_W'(d);
    tick();
    bus.delay_we = 1'b0;
    dly_m[ch] = d;
  endtask

  task automatic read_out(input int a, output longint v);
    bus.rd_addr = ADDR_W'(a);
    tick();
    v = longint'(bus.rd_data);
  endtask

  task automatic check_model(input string tag, input int n_samp);
    longint v;
    for (int i = 0; i < n_samp; i++) begin
      read_out(i, v);
      check($sformatf("%s[%0d]", tag, i), v, exp_out(i));
    end
  endtask

  // mode 0: plain run; 1: stray start and delay write while busy; 2: reset at t+7
  task automatic run(input string tag, input int n_samp, input int mode);
    int k, extra;
    longint lat;
    bus.num_samples = NS_W'(n_samp);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 1;
    check({tag, "_busy_rise"}, bus.busy, (n_samp > 0) ? 1 : 0);
    while (!bus.done && k < n_samp * NUM_CH + 10) begin
      if (mode == 1 && k == 4) bus.start = 1'b1;
      if (mode == 1 && k == 5) begin
        bus.start = 1'b0;
        check({tag, "_busy_mid"}, bus.busy, 1);
      end
      if (mode == 1 && k == 8) begin
        bus.delay_we = 1'b1; bus.delay_ch = '0; bus.delay_val = DELAY_W'(dly_m[0] + 3);
      end
      if (mode == 1 && k == 9) bus.delay_we = 1'b0;
      if (mode == 2 && k == 6) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) dly_m[c] = 0;
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_done"}, bus.done, 0);
        check({tag, "_rst_rd_data"}, bus.rd_data, 0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
          tick();
          if (bus.done || bus.busy) extra++;
        end
        check({tag, "_rst_quiet"}, extra, 0);
        return;
      end
      tick();
      k++;
    end
    lat = (n_samp == 0) ? 1 : n_samp * NUM_CH + 3;
    check({tag, "_done_lat"}, bus.done ? k : -1, lat);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    tick();
    check({tag, "_done_width"}, bus.done, 0);
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (bus.done) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    longint v;
    int n;
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.delay_we = 1'b0; bus.delay_ch = '0; bus.delay_val = '0;
    bus.num_samples = '0; bus.start = 1'b0; bus.rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) dly_m[c] = 0;
    tick(); tick();
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    tick();

    // Ramp with zero delay
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 8; a++) wr_sample(c, a, a);
    run("ramp", 8, 0);
    for (int i = 0; i < 8; i++) begin
      read_out(i, v);
      check($sformatf("ramp_out[%0d]", i), v, i * OUT_MUL);
    end

    // Delay ramp on constant data
    for (int c = 0; c < NUM_CH; c++) begin
      set_delay(c, c);
      for (int a = 0; a < 6; a++) wr_sample(c, a, 400);
    end
    run("dramp", 6, 0);
    for (int i = 0; i < 6; i++) begin
      read_out(i, v);
      check($sformatf("dramp_out[%0d]", i), v, ((i < 3) ? (i + 1) * 100 : 400) * OUT_MUL);
    end

    // Impulse aligned by the delays
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 16; a++) wr_sample(c, a, (a == 10 - c) ? 4000 : 0);
    run("impulse", 16, 0);
    for (int i = 0; i < 16; i++) begin
      read_out(i, v);
      check($sformatf("impulse_out[%0d]", i), v, (i == 10) ? 4000 * OUT_MUL : 0);
    end

    // Handshake: stray start and delay write during a run are ignored
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 5; a++) wr_sample(c, a, $urandom_range(0, 4095));
    run("hs", 5, 1);
    check_model("hs_out", 5);

    // Zero length after preloading output 0 with 0xABC
    for (int c = 0; c < NUM_CH; c++) begin
      set_delay(c, 0);
      wr_sample(c, 0, 'hABC);
    end
    run("pre", 1, 0);
    run("zero", 0, 0);
    read_out(0, v);
    check("zero_keep_out0", v, 'hABC * OUT_MUL);

    // Randomised runs against the reference model
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      for (int c = 0; c < NUM_CH; c++)
        set_delay(c, ($urandom_range(0, 7) == 0) ? $urandom_range(41, 255) : $urandom_range(0, 12));
      for (int c = 0; c < NUM_CH; c++)
        for (int a = 0; a < n; a++) wr_sample(c, a, $urandom_range(0, 4095));
      run($sformatf("rnd%0d", r), n, 0);
      check_model($sformatf("rnd%0d_out", r), n);
    end

    // Reset mid-run clears delays; rerun on constant data
    for (int c = 0; c < NUM_CH; c++) begin
      set_delay(c, NUM_CH - 1 - c);
      for (int a = 0; a < 5; a++) wr_sample(c, a, 400);
    end
    run("midrst", 5, 2);
    run("rerun", 4, 0);
    read_out(0, v);
    check("rerun_out0", v, 400 * OUT_MUL);
    check_model("rerun_out", 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
